// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit
//   XLEN_DEFAULT       operand/result width
//   REG_ADDR_W_DEFAULT destination register index width
//   muldiv_op_e        funct3 encodings of the M-extension ops
//   muldiv_state_e     unit FSM states
package muldiv_pkg;
    localparam int XLEN_DEFAULT       = 32;
    localparam int REG_ADDR_W_DEFAULT = 5;
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;
    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} muldiv_state_e;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result handshake bundle between the core and the muldiv unit
//   master (core):  drives flush, in_valid/in_op/in_a/in_b/in_rd, out_ready
//   slave  (unit):  drives in_ready, out_valid/out_result/out_rd/out_wen/out_err
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    muldiv_op_e            in_op;
    logic [XLEN-1:0]       in_a;
    logic [XLEN-1:0]       in_b;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_result;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_wen;
    logic                  out_err;
    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wen, out_err
    );
    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wen, out_err
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration on the {hi, lo} register pair
//   i_is_div  select restore-subtract (1) or shift-add (0); present only with MULDIV_DIV_EN
//   i_hi/i_lo accumulator high half / multiplier-or-dividend-and-quotient low half
//   i_b       multiplicand or divisor magnitude
//   o_hi/o_lo next {hi, lo}
// Build option: MULDIV_DIV_EN adds the restoring-division datapath.
module muldiv_step #(
    parameter int XLEN = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic            i_is_div,
`endif
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);
    logic [XLEN:0] w_sum;
    // Add the multiplicand when the multiplier LSB is set, then shift the pair right.
    assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
`ifdef MULDIV_DIV_EN
    logic [XLEN:0]   w_shl;
    logic [XLEN-1:0] w_diff;
    logic            w_fit;
    // Partial remainder is always below the divisor, so the shifted value fits XLEN+1 bits
    // and a successful subtraction leaves a result that fits XLEN bits.
    assign w_shl  = {i_hi, i_lo[XLEN-1]};
    assign w_fit  = w_shl >= {1'b0, i_b};
    assign w_diff = w_shl[XLEN-1:0] - i_b;
    assign o_hi   = i_is_div ? (w_fit ? w_diff : w_shl[XLEN-1:0]) : w_sum[XLEN:1];
    assign o_lo   = i_is_div ? {i_lo[XLEN-2:0], w_fit} : {w_sum[0], i_lo[XLEN-1:1]};
`else
    assign o_hi   = w_sum[XLEN:1];
    assign o_lo   = {w_sum[0], i_lo[XLEN-1:1]};
`endif
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_if.slave: flush, in_* request handshake, out_* result handshake
// Build option: MULDIV_DIV_EN enables DIV/DIVU/REM/REMU; without it those ops
// complete immediately with out_result=0 and out_err=1.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam logic [5:0] LAST = 6'(XLEN - 1);
    muldiv_state_e         r_state, w_state_n;
    logic [5:0]            r_cnt;
    logic [XLEN-1:0]       r_hi, r_lo, r_b, r_result;
    logic [1:0]            r_fn;
    logic                  r_neg, r_err;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  w_accept, w_sgn_a, w_sgn_b, w_sa, w_sb, w_neg, w_fast, w_fast_err;
    logic [XLEN-1:0]       w_mag_a, w_mag_b, w_fast_res, w_hi_n, w_lo_n, w_mul_res, w_fix_res;
    logic [2*XLEN-1:0]     w_prod;
    assign w_accept = bus.in_valid & (r_state == IDLE) & ~bus.flush;
    assign w_sgn_a  = bus.in_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign w_sgn_b  = bus.in_op inside {OP_MULH, OP_DIV, OP_REM};
    assign w_sa     = w_sgn_a & bus.in_a[XLEN-1];
    assign w_sb     = w_sgn_b & bus.in_b[XLEN-1];
    assign w_mag_a  = w_sa ? -bus.in_a : bus.in_a;
    assign w_mag_b  = w_sb ? -bus.in_b : bus.in_b;
    // Remainder follows the dividend's sign; products and quotients use sa^sb.
    assign w_neg    = (bus.in_op == OP_REM) ? w_sa : w_sa ^ w_sb;
`ifdef MULDIV_DIV_EN
    logic            r_div;
    logic            w_div0, w_ovf;
    logic [XLEN-1:0] w_div_mag, w_div_res;
    assign w_div0     = bus.in_op[2] & (bus.in_b == '0);
    assign w_ovf      = bus.in_op inside {OP_DIV, OP_REM} & (bus.in_a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.in_b);
    assign w_fast     = w_div0 | w_ovf;
    // funct3[1] separates REM* from DIV*; overflow quotient equals the dividend (INT_MIN).
    assign w_fast_res = w_div0 ? (bus.in_op[1] ? bus.in_a : '1) : (bus.in_op[1] ? '0 : bus.in_a);
    assign w_fast_err = 1'b0;
    assign w_div_mag  = r_fn[1] ? r_hi : r_lo;
    assign w_div_res  = r_neg ? -w_div_mag : w_div_mag;
    assign w_fix_res  = r_div ? w_div_res : w_mul_res;
    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_is_div (r_div),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_b      (r_b),
        .o_hi     (w_hi_n),
        .o_lo     (w_lo_n)
    );
`else
    assign w_fast     = bus.in_op[2];
    assign w_fast_res = '0;
    assign w_fast_err = 1'b1;
    assign w_fix_res  = w_mul_res;
    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_hi (r_hi),
        .i_lo (r_lo),
        .i_b  (r_b),
        .o_hi (w_hi_n),
        .o_lo (w_lo_n)
    );
`endif
    assign w_prod    = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_mul_res = (r_fn == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    always_comb begin
        w_state_n = bus.flush ? IDLE :
                    r_state == IDLE ? (w_accept ? (w_fast ? DONE : BUSY) : IDLE) :
                    r_state == BUSY ? ((r_cnt == LAST) ? FIX : BUSY) :
                    r_state == FIX  ? DONE :
                    (bus.out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_fn     <= '0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
            r_rd     <= '0;
            r_result <= '0;
`ifdef MULDIV_DIV_EN
            r_div    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= w_mag_a;
            r_b      <= w_mag_b;
            r_fn     <= bus.in_op[1:0];
            r_neg    <= w_neg;
            r_err    <= w_fast & w_fast_err;
            r_rd     <= bus.in_rd;
            r_result <= w_fast_res;
`ifdef MULDIV_DIV_EN
            r_div    <= bus.in_op[2];
`endif
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 6'd1;
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
        end else if (r_state == FIX) begin
            r_result <= w_fix_res;
        end
    end
    assign bus.in_ready   = r_state == IDLE;
    assign bus.out_valid  = r_state == DONE;
    assign bus.out_result = r_result;
    assign bus.out_rd     = r_rd;
    assign bus.out_err    = r_err;
    assign bus.out_wen    = (r_state == DONE) & (r_rd != '0) & ~r_err;
endmodule
